// File: rtl/fifo_drain_seq.sv
// Read sequencer that drains one of N_CH receive FIFOs on command, either until
// empty or for a fixed burst, with back-pressure, inter-read gap and abort.
module fifo_drain_seq #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned CH_W  = 1,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_tick,
    input  logic             abort,
    input  logic             mode,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [CH_W-1:0]  ch_sel,
    input  logic [N_CH-1:0]  rx_empty,
    input  logic             dst_ready,
    output logic [N_CH-1:0]  rd,
    output logic             busy,
    output logic             done_tick,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned      GAP_W    = 8;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] count_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [N_CH-1:0]  rd_d;
    logic             busy_d;
    logic             done_d;
    logic [N_CH-1:0]  sel_mask_c;
    logic             sel_empty_c;

    // One-hot select of the latched channel, reused for the strobe and empty lookup
    assign sel_mask_c  = N_CH'(1) << ch_q;
    assign sel_empty_c = |(rx_empty & sel_mask_c);

    // Next-state and next-output decode
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        mode_d  = mode_q;
        len_d   = len_q;
        count_d = count;
        gap_d   = gap_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_tick) begin
                    ch_d    = ch_sel;
                    mode_d  = mode;
                    len_d   = burst_len;
                    count_d = '0;
                    state_d = (32'(ch_sel) >= N_CH) ? S_DONE : S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (sel_empty_c) begin
                    state_d = S_DONE;
                end else if (mode_q && (count == len_q)) begin
                    state_d = S_DONE;
                end else if (count == '1) begin
                    state_d = S_DONE;
                end else if (dst_ready) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                count_d = count + CNT_W'(1);
                if (GAP > 0) begin
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (gap_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state decodes to
        rd_d   = (state_d == S_READ) ? sel_mask_c : '0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, transfer context and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            mode_q    <= 1'b0;
            len_q     <= '0;
            gap_q     <= '0;
            count     <= '0;
            rd        <= '0;
            busy      <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            count     <= count_d;
            rd        <= rd_d;
            busy      <= busy_d;
            done_tick <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain_seq.sv
// Bench for fifo_drain_seq: two instances (GAP=0 and GAP=3) share stimulus; each
// has its own FIFO occupancy model and a procedural timeline model of the outputs.
module tb_fifo_drain_seq;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned CH_W  = 2;
    localparam int unsigned CNT_W = 8;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       start_tick = 1'b0;
    logic       abort      = 1'b0;
    logic       mode       = 1'b0;
    logic       dst_ready  = 1'b1;
    logic [7:0] burst_len  = 8'd0;
    logic [1:0] ch_sel     = 2'd0;

    int base[2][2];
    int popped[2][2];
    int n_cmp = 0;
    int n_err = 0;
    int log0[$];
    int log1[$];
    int dk[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int unsigned G = 3 * g;
        logic [1:0] rx_empty;
        logic [1:0] rd;
        logic       busy;
        logic       done_tick;
        logic [7:0] count;
        logic [1:0] e_rd   = 2'd0;
        logic       e_busy = 1'b0;
        logic       e_done = 1'b0;
        logic [7:0] e_cnt  = 8'd0;

        assign rx_empty[0] = (base[g][0] - popped[g][0]) <= 0;
        assign rx_empty[1] = (base[g][1] - popped[g][1]) <= 0;

        fifo_drain_seq #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W), .GAP(G)) dut (
            .clk       (clk),
            .reset     (reset),
            .start_tick(start_tick),
            .abort     (abort),
            .mode      (mode),
            .burst_len (burst_len),
            .ch_sel    (ch_sel),
            .rx_empty  (rx_empty),
            .dst_ready (dst_ready),
            .rd        (rd),
            .busy      (busy),
            .done_tick (done_tick),
            .count     (count)
        );

        // Timeline model: walks one transfer as a sequence of clock edges
        initial begin : model
            logic [1:0] mch;
            logic       mmd;
            logic [7:0] mln;
            bit         fin;
            bit         rh;
            forever begin
                if (reset) begin
                    e_rd = 2'd0; e_busy = 1'b0; e_done = 1'b0; e_cnt = 8'd0;
                    wait (!reset);
                end
                e_rd = 2'd0; e_busy = 1'b0; e_done = 1'b0;
                @(posedge clk or posedge reset);
                if (!reset && start_tick) begin
                    mch = ch_sel; mmd = mode; mln = burst_len;
                    e_cnt = 8'd0; rh = 1'b0;
                    fin = (mch >= 2'd2);
                    e_busy = 1'b1;
                    while (!fin && !rh) begin
                        @(posedge clk or posedge reset);
                        if (reset) rh = 1'b1;
                        else if (abort || rx_empty[mch] || (mmd && e_cnt == mln) || e_cnt == 8'hFF)
                            fin = 1'b1;
                        else if (dst_ready) begin
                            e_rd = 2'b01 << mch;
                            @(posedge clk or posedge reset);
                            e_rd = 2'd0;
                            if (reset) rh = 1'b1;
                            else begin
                                e_cnt = e_cnt + 8'd1;
                                for (int k = 1; k <= int'(G) && !fin && !rh; k++) begin
                                    @(posedge clk or posedge reset);
                                    if (reset) rh = 1'b1;
                                    else if (abort) fin = 1'b1;
                                end
                            end
                        end
                    end
                    if (!rh) begin
                        e_rd = 2'd0; e_done = 1'b1;
                        @(posedge clk or posedge reset);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input string tag, input logic [1:0] r, input logic [1:0] er,
                            input logic b, input logic eb, input logic d, input logic ed,
                            input logic [7:0] c, input logic [7:0] ec);
        chk({tag, ".rd"}, 32'(r), 32'(er));
        chk({tag, ".busy"}, 32'(b), 32'(eb));
        chk({tag, ".done"}, 32'(d), 32'(ed));
        chk({tag, ".count"}, 32'(c), 32'(ec));
    endtask

    // Every bench step goes through here: compare against the model, then pop FIFOs
    task automatic nclk();
        @(negedge clk);
        cmp_inst("i0", inst[0].rd, inst[0].e_rd, inst[0].busy, inst[0].e_busy,
                 inst[0].done_tick, inst[0].e_done, inst[0].count, inst[0].e_cnt);
        cmp_inst("i1", inst[1].rd, inst[1].e_rd, inst[1].busy, inst[1].e_busy,
                 inst[1].done_tick, inst[1].e_done, inst[1].count, inst[1].e_cnt);
        for (int c = 0; c < 2; c++) begin
            if (inst[0].rd[c] === 1'b1) popped[0][c]++;
            if (inst[1].rd[c] === 1'b1) popped[1][c]++;
        end
    endtask

    task automatic load(input int c, input int n);
        for (int i = 0; i < 2; i++) base[i][c] = popped[i][c] + n;
    endtask

    function automatic int rem(input int i, input int c);
        return base[i][c] - popped[i][c];
    endfunction

    // Start a transfer in cycle 0 and log model rd/done cycles until both finish
    task automatic run(input logic [1:0] ch, input logic md, input logic [7:0] ln,
                       input int rdy_k, input int abort_k, input int restart_k);
        nclk();
        ch_sel = ch; mode = md; burst_len = ln; start_tick = 1'b1;
        abort = (abort_k == 0); dst_ready = (rdy_k == 0);
        log0.delete(); log1.delete(); dk[0] = -1; dk[1] = -1;
        for (int k = 1; k <= 60 && (dk[0] < 0 || dk[1] < 0); k++) begin
            nclk();
            start_tick = (k == restart_k);
            if (k == restart_k) begin ch_sel = 2'd1; mode = 1'b1; burst_len = 8'd0; end
            abort = (k == abort_k);
            if (k == rdy_k) dst_ready = 1'b1;
            if (inst[0].e_rd != 2'd0) log0.push_back(k);
            if (inst[1].e_rd != 2'd0) log1.push_back(k);
            if (inst[0].e_done && dk[0] < 0) dk[0] = k;
            if (inst[1].e_done && dk[1] < 0) dk[1] = k;
        end
        start_tick = 1'b0; abort = 1'b0; dst_ready = 1'b1;
    endtask

    task automatic chk_log(input string nm, input int i, input int n,
                           input int a, input int b, input int c);
        int exp[3];
        int sz;
        exp = '{a, b, c};
        sz = (i == 0) ? log0.size() : log1.size();
        chk({nm, "_nrd"}, sz, n);
        for (int j = 0; j < n && j < sz; j++)
            chk({nm, "_rdcyc"}, (i == 0) ? log0[j] : log1[j], exp[j]);
    endtask

    initial begin
        nclk();
        chk("rst_busy0", 32'(inst[0].busy), 0);
        chk("rst_rd1", 32'(inst[1].rd), 0);
        chk("rst_cnt0", 32'(inst[0].count), 0);
        nclk();
        #2 reset = 1'b0;

        // drain 3 words from ch0
        load(0, 3);
        run(2'd0, 1'b0, 8'd0, 0, -1, -1);
        chk_log("t1_i0", 0, 3, 2, 4, 6);
        chk_log("t1_i1", 1, 3, 2, 7, 12);
        chk("t1_done0", dk[0], 8);
        chk("t1_done1", dk[1], 17);
        chk("t1_cnt0", 32'(inst[0].count), 3);
        chk("t1_cnt1", 32'(inst[1].count), 3);
        chk("t1_rem0", rem(0, 0), 0);

        // burst of 2 from ch1 holding 5
        load(1, 5);
        run(2'd1, 1'b1, 8'd2, 0, -1, -1);
        chk_log("t2_i0", 0, 2, 2, 4, 0);
        chk_log("t2_i1", 1, 2, 2, 7, 0);
        chk("t2_done0", dk[0], 6);
        chk("t2_done1", dk[1], 12);
        chk("t2_cnt0", 32'(inst[0].count), 2);
        chk("t2_rem0", rem(0, 1), 3);
        chk("t2_rem1", rem(1, 1), 3);

        // downstream not ready until cycle 5
        load(0, 3);
        run(2'd0, 1'b0, 8'd0, 5, -1, -1);
        chk_log("t4_i0", 0, 3, 6, 8, 10);
        chk_log("t4_i1", 1, 3, 6, 11, 16);
        chk("t4_done0", dk[0], 12);
        chk("t4_done1", dk[1], 21);

        // abort in cycle 4 (GAP for i1, READ for i0) plus ignored restart in cycle 3
        load(0, 3);
        run(2'd0, 1'b0, 8'd0, 0, 4, 3);
        chk_log("t5_i0", 0, 3, 2, 4, 6);
        chk_log("t5_i1", 1, 1, 2, 0, 0);
        chk("t5_done0", dk[0], 8);
        chk("t5_done1", dk[1], 5);
        chk("t5_cnt1", 32'(inst[1].count), 1);
        chk("t5_rem1", rem(1, 0), 2);

        // start and abort together in IDLE: start wins
        load(1, 1);
        run(2'd1, 1'b0, 8'd0, 0, 0, -1);
        chk_log("t7_i0", 0, 1, 2, 0, 0);
        chk("t7_done0", dk[0], 4);
        chk("t7_done1", dk[1], 7);

        // zero-length burst
        load(0, 2);
        run(2'd0, 1'b1, 8'd0, 0, -1, -1);
        chk_log("t8_i0", 0, 0, 0, 0, 0);
        chk("t8_done0", dk[0], 2);
        chk("t8_cnt1", 32'(inst[1].count), 0);

        // reset asserted during the second READ of i0
        load(0, 3);
        nclk();
        ch_sel = 2'd0; mode = 1'b0; dst_ready = 1'b1; abort = 1'b0; start_tick = 1'b1;
        nclk();
        start_tick = 1'b0;
        repeat (3) nclk();
        chk("t6_rd_pre0", 32'(inst[0].rd), 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rd0", 32'(inst[0].rd), 0);
        chk("t6_busy0", 32'(inst[0].busy), 0);
        chk("t6_cnt0", 32'(inst[0].count), 0);
        chk("t6_busy1", 32'(inst[1].busy), 0);
        chk("t6_cnt1", 32'(inst[1].count), 0);
        nclk();
        #2 reset = 1'b0;

        // out-of-range channel
        load(0, 3);
        run(2'd3, 1'b0, 8'd0, 0, -1, -1);
        chk_log("t6b_i0", 0, 0, 0, 0, 0);
        chk_log("t6b_i1", 1, 0, 0, 0, 0);
        chk("t6b_done0", dk[0], 1);
        chk("t6b_done1", dk[1], 1);
        chk("t6b_cnt0", 32'(inst[0].count), 0);

        nclk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
